ser_tx: RTL and testbench

//  Serial frame transmitter; the sending end of the single-wire serial link used by the register labs.

---
 rtl/ser_tx.sv | 101 ++++++++++
 tb/tb_ser_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ser_tx.sv
// Serial frame transmitter: start bit (0), DATA_W data bits LSB first, stop bit (1),
// each bit held for DIV clocks. Parallel word accepted on a valid/ready handshake.
module ser_tx #(
    parameter int DATA_W = 8,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int DIV_CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [DIV_CW-1:0]   div_cnt;
    logic [BIT_CW-1:0]   bit_cnt;
    logic [DATA_W-1:0]   shift;
    logic                accept;
    logic                tick;
    logic                last_bit;

    assign din_ready = (state == IDLE);

    // Next-state decode: every non-idle state advances only on a bit boundary.
    always_comb begin
        accept     = 1'b0;
        tick       = 1'b0;
        last_bit   = 1'b0;
        next_state = state;
        accept     = (state == IDLE) && din_valid;
        tick       = (div_cnt == DIV_CW'(DIV - 1));
        last_bit   = (bit_cnt == BIT_CW'(DATA_W - 1));
        case (state)
            IDLE:    if (accept) next_state = START;
            START:   if (tick) next_state = DATA;
            DATA:    if (tick && last_bit) next_state = STOP;
            STOP:    if (tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Divide counter: restarts at every bit boundary and is held at zero in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        div_cnt <= '0;
        else if (state == IDLE || tick) div_cnt <= '0;
        else                            div_cnt <= div_cnt + DIV_CW'(1);
    end

    // Bit counter: counts data bits sent, cleared outside DATA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    bit_cnt <= '0;
        else if (state != DATA)     bit_cnt <= '0;
        else if (tick)              bit_cnt <= last_bit ? '0 : bit_cnt + BIT_CW'(1);
    end

    // Shift register: loaded on acceptance, shifted right at each data bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        shift <= '0;
        else if (accept)                shift <= din;
        else if (state == DATA && tick) shift <= shift >> 1;
    end

    // Registered outputs: tx follows the current state one clock later,
    // busy and done are derived from the transition being taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx   <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
                default: tx <= 1'b1;
            endcase
            busy <= (next_state != IDLE);
            done <= (state == STOP) && tick;
        end
    end

endmodule

// File: tb/tb_ser_tx.sv
// Self-checking bench for ser_tx: two instances (DIV=4 and DIV=1) share stimulus and are
// compared every clock against a timeline model of the frame measured from the accepting edge.
module tb_ser_tx;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready_a, tx_a, busy_a, done_a;
    logic         din_ready_b, tx_b, busy_b, done_b;

    int checks = 0;
    int passes = 0;
    int n = 0;

    bit           have_a = 0, have_b = 0;
    int           la_a = 0, la_b = 0;
    logic [W-1:0] w_a = '0, w_b = '0;

    int done_cnt_a = 0;
    int last_done_a = 0, prev_done_a = 0, last_done_b = 0;

    ser_tx #(.DATA_W(W), .DIV(4)) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    ser_tx #(.DATA_W(W), .DIV(1)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, n);
    endtask

    // Reference: an accept can happen once the previous frame plus its done cycle is over.
    task automatic model_edge(inout bit have, inout int la, inout logic [W-1:0] w,
                              input int div, input logic v, input logic [W-1:0] d);
        int frame;
        frame = (W + 2) * div;
        if (v && (!have || (n - 1 - la) >= frame)) begin
            have = 1;
            la   = n;
            w    = d;
        end
    endtask

    task automatic compare_one(input string who, input bit have, input int la,
                               input logic [W-1:0] w, input int div,
                               input logic tx_o, input logic busy_o,
                               input logic done_o, input logic ready_o);
        int   frame, t;
        logic e_tx, e_busy, e_done, e_ready;
        frame   = (W + 2) * div;
        t       = n - la;
        e_tx    = 1'b1;
        e_busy  = have && (t <= frame - 1);
        e_done  = have && (t == frame);
        e_ready = !have || (t >= frame);
        if (have) begin
            if (t >= 1 && t <= div) e_tx = 1'b0;
            else if (t >= div + 1 && t <= div * (W + 1)) e_tx = w[(t - 1) / div - 1];
        end
        check($sformatf("%s tx", who), {31'd0, tx_o}, {31'd0, e_tx});
        check($sformatf("%s busy", who), {31'd0, busy_o}, {31'd0, e_busy});
        check($sformatf("%s done", who), {31'd0, done_o}, {31'd0, e_done});
        check($sformatf("%s din_ready", who), {31'd0, ready_o}, {31'd0, e_ready});
    endtask

    task automatic step(input logic v, input logic [W-1:0] d);
        din_valid = v;
        din       = d;
        @(posedge clk);
        n++;
        model_edge(have_a, la_a, w_a, 4, v, d);
        model_edge(have_b, la_b, w_b, 1, v, d);
        #1;
        compare_one("div4", have_a, la_a, w_a, 4, tx_a, busy_a, done_a, din_ready_a);
        compare_one("div1", have_b, la_b, w_b, 1, tx_b, busy_b, done_b, din_ready_b);
        if (done_a) begin
            done_cnt_a++;
            prev_done_a = last_done_a;
            last_done_a = n;
        end
        if (done_b) last_done_b = n;
    endtask

    // Pulse reset between edges and check the forced outputs before any edge occurs.
    task automatic do_reset();
        #5 rst = 1'b1;
        #1;
        check("rst tx div4", {31'd0, tx_a}, 32'd1);
        check("rst din_ready div4", {31'd0, din_ready_a}, 32'd1);
        check("rst busy div4", {31'd0, busy_a}, 32'd0);
        check("rst done div4", {31'd0, done_a}, 32'd0);
        check("rst tx div1", {31'd0, tx_b}, 32'd1);
        check("rst din_ready div1", {31'd0, din_ready_b}, 32'd1);
        check("rst busy div1", {31'd0, busy_b}, 32'd0);
        check("rst done div1", {31'd0, done_b}, 32'd0);
        #9 rst = 1'b0;
        have_a = 0;
        have_b = 0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, W'($urandom));
    endtask

    initial begin
        int a0, cnt0;
        rst       = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        #1;
        do_reset();
        idle(3);

        // Single A5 frame with a one-cycle valid; din scrambled afterwards.
        step(1'b1, 8'hA5);
        a0 = n;
        idle(45);
        check("a5 done latency div4", last_done_a - a0, 32'd40);
        check("a5 done latency div1", last_done_b - a0, 32'd10);

        // Back-to-back 00 then FF with valid held until the second accept.
        cnt0 = done_cnt_a;
        step(1'b1, 8'h00);
        for (int i = 0; i < 41; i++) step(1'b1, 8'hFF);
        idle(45);
        check("b2b done count", done_cnt_a - cnt0, 32'd2);
        check("b2b done spacing", last_done_a - prev_done_a, 32'd41);

        // din changes right after acceptance.
        step(1'b1, 8'hC3);
        step(1'b0, 8'h3C);
        idle(45);

        // Reset in the third data bit, then a fresh frame.
        cnt0 = done_cnt_a;
        step(1'b1, 8'h5A);
        a0 = n;
        while (n - a0 < 14) step(1'b0, W'($urandom));
        do_reset();
        idle(45);
        check("no done after abort", done_cnt_a - cnt0, 32'd0);
        step(1'b1, 8'h81);
        idle(45);

        // Pattern of interest for the DIV=1 instance.
        step(1'b1, 8'h55);
        a0 = n;
        idle(45);
        check("55 done latency div1", last_done_b - a0, 32'd10);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0), W'($urandom));
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
